// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N producer channels in, one consumer out.
// slave  : the multiplexer's view (accepts producer words, drives the consumer)
// master : the surrounding system's view (drives producers, acts as consumer)
interface stream_mux_if #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*SIZE-1:0] in_data;
    logic [CHANNELS-1:0]      in_valid;
    logic [CHANNELS-1:0]      in_ready;
    logic [SIZE-1:0]          out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );
endinterface

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with an internal arbiter and a
// registered output stage (one word per cycle at full throughput).
//
// Optional build macro STREAM_MUX_RR_EN:
//   defined   -> round-robin arbitration from a last-grant pointer
//   undefined -> fixed priority, lowest requesting index wins
//
// in_ready is gated by rst_n so no producer sees an accept while reset is held.
module stream_mux #(
    parameter int  SIZE     = 32,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic        clk,
    input  logic        rst_n,
    stream_mux_if.slave bus
);

    logic                load_ok;
    logic                xfer;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SIZE-1:0]     sel_data;

    assign load_ok      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = grant & {CHANNELS{load_ok & rst_n}};
    assign xfer         = |(bus.in_valid & bus.in_ready);

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] ptr;

    // Round-robin search: first requester at ptr+1, ptr+2, ... modulo CHANNELS.
    always_comb begin
        logic             found;
        logic [SEL_W:0]   cand;
        logic [SEL_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(k + 1);
            if (cand >= (SEL_W+1)'(CHANNELS)) begin
                cand = cand - (SEL_W+1)'(CHANNELS);
            end
            cand_idx = cand[SEL_W-1:0];
            if (!found && bus.in_valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    // Last-grant pointer moves only when a word is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            ptr <= grant_idx;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && bus.in_valid[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end
`endif

    // AND-OR select of the granted channel's data word.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*SIZE +: SIZE];
            end
        end
    end

    // Output register: load on input transfer, drain on output transfer, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_sel   <= grant_idx;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux (4 channels x 32 bits).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_stream_mux;
    localparam int SIZE = 32;
    localparam int CH   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    stream_mux_if #(.SIZE(SIZE), .CHANNELS(CH)) bus ();

    stream_mux #(.SIZE(SIZE), .CHANNELS(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [SIZE-1:0] d);
        bus.in_data[ch*SIZE +: SIZE] = d;
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int c = 0; c < CH; c++) set_data(c, 32'hC0DE_0000 + 32'(c));
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        tests_run++;
        if (bus.out_sel !== 2'd0) begin
            tests_failed++; $display("FAIL reset_out_sel: got %0d expected 0", bus.out_sel);
        end
        tests_run++;
        if (bus.in_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL reset_first_grant: got %b expected 0001", bus.in_ready);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 32'hC0DE_0000) begin
            tests_failed++;
            $display("FAIL reset_first_word: got v=%b sel=%0d data=%h expected v=1 sel=0 data=c0de0000",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_single_channel();
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b1;
        set_data(2, 32'hDEAD_BEEF);
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL single_in_ready: got %b expected 0100", bus.in_ready);
        end
        tick();
        bus.in_valid = '0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.out_sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_out: got v=%b data=%h sel=%0d expected v=1 data=deadbeef sel=2",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b1;
        set_data(1, 32'h1111_2222);
        tick();
        bus.in_valid  = 4'b1000;
        set_data(3, 32'h3333_4444);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (bus.in_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", i, bus.in_ready);
            end
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1111_2222 || bus.out_sel !== 2'd1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got v=%b data=%h sel=%0d expected v=1 data=11112222 sel=1",
                         i, bus.out_valid, bus.out_data, bus.out_sel);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL release_in_ready: got %b expected 1000", bus.in_ready);
        end
        tick();
        bus.in_valid = '0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3333_4444 || bus.out_sel !== 2'd3) begin
            tests_failed++;
            $display("FAIL swap_word: got v=%b data=%h sel=%0d expected v=1 data=33334444 sel=3",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h3333_4444 || bus.out_sel !== 2'd3) begin
            tests_failed++;
            $display("FAIL drain: got v=%b data=%h sel=%0d expected v=0 data=33334444 sel=3",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

`ifdef STREAM_MUX_RR_EN
    task automatic test_arbitration();
        int seq_a[6] = '{0, 1, 2, 3, 0, 1};
        int seq_b[7] = '{0, 1, 2, 3, 0, 2, 3};
        for (int c = 0; c < CH; c++) set_data(c, 32'hA000_0000 + 32'(c));
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_sel) != seq_a[i]
                || bus.out_data !== 32'hA000_0000 + 32'(seq_a[i])) begin
                tests_failed++;
                $display("FAIL rr_all[%0d]: got v=%b sel=%0d data=%h expected sel=%0d",
                         i, bus.out_valid, bus.out_sel, bus.out_data, seq_a[i]);
            end
        end
        do_reset();
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (seq_b[i] == 1) bus.in_valid[1] = 1'b0;
            tests_run++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_sel) != seq_b[i]) begin
                tests_failed++;
                $display("FAIL rr_drop1[%0d]: got v=%b sel=%0d expected sel=%0d",
                         i, bus.out_valid, bus.out_sel, seq_b[i]);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask
`else
    task automatic test_arbitration();
        for (int c = 0; c < CH; c++) set_data(c, 32'hB000_0000 + 32'(c));
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (bus.in_ready !== 4'b0001) begin
                tests_failed++; $display("FAIL fp_in_ready[%0d]: got %b expected 0001", i, bus.in_ready);
            end
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 32'hB000_0000) begin
                tests_failed++;
                $display("FAIL fp_sel[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=0 data=b0000000",
                         i, bus.out_valid, bus.out_sel, bus.out_data);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask
`endif

    task automatic test_midstream_reset();
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 4'b0001;
        set_data(0, 32'h5555_AAAA);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1010;
        set_data(1, 32'h0101_0101);
        set_data(3, 32'h0303_0303);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mid_preload: got v=%b expected 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b data=%h in_ready=%b expected v=0 data=0 in_ready=0000",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL mid_regrant: got %b expected 0010", bus.in_ready);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 32'h0101_0101) begin
            tests_failed++;
            $display("FAIL mid_first_word: got v=%b sel=%0d data=%h expected v=1 sel=1 data=01010101",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
        bus.in_valid = '0;
        tick();
    endtask

`ifdef STREAM_MUX_RR_EN
    int m_last;
    // Round-robin rule: first requester after the last granted channel, wrapping.
    function automatic int model_pick(input logic [CH-1:0] v);
        for (int k = 1; k <= CH; k++) begin
            if (v[(m_last + k) % CH]) return (m_last + k) % CH;
        end
        return -1;
    endfunction
`else
    // Fixed-priority rule: lowest requesting index.
    function automatic int model_pick(input logic [CH-1:0] v);
        for (int c = 0; c < CH; c++) begin
            if (v[c]) return c;
        end
        return -1;
    endfunction
`endif

    task automatic test_random();
        logic [CH-1:0]   pv;
        logic [SIZE-1:0] pd [CH];
        logic            m_valid;
        logic [SIZE-1:0] m_data;
        int              m_sel;
        logic [CH-1:0]   exp_rdy;
        int              g;
        logic            ld_ok;
        do_reset();
        pv      = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        for (int c = 0; c < CH; c++) pd[c] = '0;
`ifdef STREAM_MUX_RR_EN
        m_last = CH - 1;
`endif
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!pv[c] && $urandom_range(0, 2) == 0) begin
                    pv[c] = 1'b1;
                    pd[c] = $urandom;
                end
                set_data(c, pd[c]);
            end
            bus.in_valid  = pv;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            ld_ok   = !m_valid || bus.out_ready;
            g       = model_pick(pv);
            exp_rdy = '0;
            if (ld_ok && g >= 0) exp_rdy[g] = 1'b1;
            #1;
            tests_run++;
            if (bus.in_ready !== exp_rdy) begin
                tests_failed++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, bus.in_ready, exp_rdy);
            end
            tick();
            if (exp_rdy != '0) begin
                m_valid = 1'b1;
                m_data  = pd[g];
                m_sel   = g;
                pv[g]   = 1'b0;
`ifdef STREAM_MUX_RR_EN
                m_last  = g;
`endif
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            tests_run++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data || int'(bus.out_sel) != m_sel) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got v=%b data=%h sel=%0d expected v=%b data=%h sel=%0d",
                         n, bus.out_valid, bus.out_data, bus.out_sel, m_valid, m_data, m_sel);
            end
        end
        bus.in_valid = '0;
        tick();
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_channel();
        test_backpressure();
        test_arbitration();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel streaming multiplexer with valid/ready handshakes, an internal arbiter and a registered output stage. It generalises the plain combinational select mux to a configurable number of channels and data width. The channel is chosen by arbitration over the requesting inputs, not by an external select. It sits between multiple CPU-side producers, such as load/store, fetch and debug request paths, and a single shared consumer, such as the memory/bus port.

## Interface
Parameters:
- SIZE, 32, data width per channel in bits
- CHANNELS, 4, number of input channels; legal range 2..16
- SEL_W, $clog2(CHANNELS), width of the channel index; derived, never overridden

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*SIZE  flattened inputs; channel i occupies bits [i*SIZE +: SIZE]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- out_data  output  SIZE  registered selected data
- out_sel  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the word

## Operation
- Output register: out_data, out_sel and out_valid.
- load_ok = !out_valid || out_ready. The register can accept a new word this cycle.
- Grant (combinational): one-hot grant[CHANNELS-1:0], chosen from in_valid by the arbitration policy (see Configuration).
  - grant is all-zero when in_valid == 0.
- in_ready = grant & {CHANNELS{load_ok}}.
  - in_ready never depends combinationally on in_valid of the same channel beyond the grant computation.
- Input transfer on channel i: in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i*SIZE +: SIZE]
  - out_sel <= i
  - out_valid <= 1
- Output transfer: out_valid && out_ready. If no input transfer occurs on the same edge, out_valid <= 0. out_data and out_sel keep their values.
- Simultaneous output and input transfer on one edge: the new word replaces the old one and out_valid stays 1. This gives full throughput, one word per cycle.
- Stall (out_valid && !out_ready):
  - in_ready = 0 on all channels.
  - out_data, out_sel and out_valid are held stable.
- Producer rule: once in_valid[i] is raised, it and in_data[i] are held until transferred. The block does not check this.
- The grant may move to another requester while stalled. That is legal because no transfer occurs.
- Arbiter state: last-grant pointer ptr (SEL_W bits).
  - Updated to i only on an input transfer from channel i.
  - Held otherwise.

## Timing
- Latency: input transfer at edge N, so out_valid is high after edge N. The word is visible to the consumer in cycle N+1.
- Throughput: 1 word/cycle while out_ready stays high and any in_valid is set.
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_sel = 0
  - ptr = CHANNELS-1, so channel 0 has first priority after reset
  - in_ready = 0 during reset
- Reset asserted mid-stream: the held word is discarded with no handshake. On release, arbitration restarts from channel 0.
- ptr wrap-around: the search order is ptr+1, ptr+2, …, modulo CHANNELS. After a grant to CHANNELS-1, the next search starts at 0.
- No combinational path from out_ready to out_data, out_sel or out_valid. The path from out_ready to in_ready is combinational via load_ok.

## Configuration
- STREAM_MUX_RR_EN defined: round-robin arbitration. The lowest-index requester at or after ptr+1 (wrapping) is granted. With CHANNELS requesters continuously valid, each channel gets exactly one grant per CHANNELS transfers.
- STREAM_MUX_RR_EN undefined: fixed priority. The lowest index with in_valid set wins. ptr logic is not built, and channel 0 can starve the others.

## Test plan
- Reset: rst_n low with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, the first transfer is from channel 0 in either mode.
- Single channel: in_valid=4'b0100, in_data ch2=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100. One cycle later out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2.
- Back-pressure: a word is held with out_ready=0 for 5 cycles -> in_ready=0 and out_data/out_sel stable throughout. With out_ready=1 the next word transfers on the same edge and out_valid stays 1.
- Round-robin (STREAM_MUX_RR_EN): all four valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1. Drop ch1 after its first grant -> sequence 0,1,2,3,0,2,3.
- Fixed priority (macro undefined): all four valid and ch0 never cleared -> out_sel=0 every cycle, with in_ready[3:1]=0.
- Mid-stream reset: rst_n pulsed low asynchronously between edges with out_valid=1 -> out_valid drops immediately. After release with in_valid=4'b1010, the first grant is channel 1.
